// File: rtl/tank_pkg.sv
// Purpose : shared direction codes and button-level bundle used by tank, Game and the issuer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package tank_pkg;

    // Direction code carried on direction_in / direction_out.
    typedef logic [2:0] direction_t;

    localparam direction_t DIR_UP    = 3'd0;
    localparam direction_t DIR_DOWN  = 3'd1;
    localparam direction_t DIR_LEFT  = 3'd2;
    localparam direction_t DIR_RIGHT = 3'd3;
    localparam direction_t DIR_STAND = 3'd4;

    // Debounced button levels, one bit per button, active-high.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_levels_t;

endpackage

// File: rtl/btn_debouncer.sv
// Purpose : 2-flop synchroniser plus stable-run debouncer for one raw push-button.
// Latency : a held level change appears on level_out 2+DEBOUNCE_CYCLES cycles after the raw edge.
// Backpressure: none; free-running every cycle.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-high reset (clears sync flops, level and counter)
//   raw_in    raw asynchronous button input
//   level_out debounced, synchronised level
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_q;
    logic          level_q;
    logic [CW-1:0] stable_cnt;

    // Two-stage synchroniser; sync_meta may go metastable and is never used elsewhere.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= raw_in;
            sync_q    <= sync_meta;
        end
    end

    // The counter measures how long the synchronised input has disagreed with the
    // accepted level. Any agreeing cycle restarts the measurement, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches the toggle point.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_q == level_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            level_q    <= ~level_q;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/tank_direction_issuer.sv
// Purpose : turns four raw player buttons into one encoded direction sample per frame tick.
// Latency : strobe every TICK_CYCLES enabled cycles; sample reflects levels one cycle before the strobe.
// Backpressure: none; the consumer must take every strobe (it counts identical samples).
//
// Ports:
//   clk                  system clock
//   rst_n                asynchronous active-high reset
//   enable               game running; low holds the frame counter at 0 and suppresses strobes
//   btn_up/down/left/right raw asynchronous active-high buttons
//   direction_out        encoded direction (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 STAND),
//                        changes only alongside a strobe or on reset
//   valid_take_direction one-cycle strobe qualifying direction_out
module tank_direction_issuer
    import tank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_CYCLES     = 833333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [2:0] direction_out,
    output logic       valid_take_direction
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic        lvl_up;
    logic        lvl_down;
    logic        lvl_left;
    logic        lvl_right;
    btn_levels_t levels;
    direction_t  enc_dir;

    logic [TW-1:0] tick_cnt;
    direction_t    dir_q;
    logic          vld_q;

    // ------------------------------------------------------------------
    // Per-button synchronise + debounce
    // ------------------------------------------------------------------
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (btn_up),
        .level_out (lvl_up)
    );

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (btn_down),
        .level_out (lvl_down)
    );

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (btn_left),
        .level_out (lvl_left)
    );

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (btn_right),
        .level_out (lvl_right)
    );

    assign levels = '{up: lvl_up, down: lvl_down, left: lvl_left, right: lvl_right};

    // ------------------------------------------------------------------
    // Direction encoder: an opposing pair cancels to STAND before the
    // fixed priority UP > DOWN > LEFT > RIGHT is applied.
    // ------------------------------------------------------------------
    always_comb begin
        enc_dir = DIR_STAND;
        if ((levels.up && levels.down) || (levels.left && levels.right)) begin
            enc_dir = DIR_STAND;
        end else if (levels.up) begin
            enc_dir = DIR_UP;
        end else if (levels.down) begin
            enc_dir = DIR_DOWN;
        end else if (levels.left) begin
            enc_dir = DIR_LEFT;
        end else if (levels.right) begin
            enc_dir = DIR_RIGHT;
        end
    end

    // ------------------------------------------------------------------
    // Frame tick and sample register. enable low wins over a wrap on the
    // same edge, so dropping enable never lets a final strobe through.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tick_cnt <= '0;
            vld_q    <= 1'b0;
            dir_q    <= DIR_STAND;
        end else begin
            vld_q <= 1'b0;
            if (!enable) begin
                tick_cnt <= '0;
            end else if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                vld_q    <= 1'b1;
                dir_q    <= enc_dir;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    assign direction_out        = dir_q;
    assign valid_take_direction = vld_q;

endmodule
